// File: rtl/fifo_loopback_engine.sv
// -----------------------------------------------------------------------------
// fifo_loopback_engine
//
// Drains the HPS-to-FPGA Avalon FIFO (through its output port) and refills the
// FPGA-to-HPS Avalon FIFO (through its input port), adding ADD_VALUE to every
// word on the way through. Flow control is done purely by polling each FIFO's
// fill-level CSR. A word is only read once space for it has been reserved
// downstream.
//
// Parameters:
//   FIFO_DEPTH       depth in words of the FPGA-to-HPS FIFO (space check)
//   ADD_VALUE        constant added (mod 2^32) to every forwarded word
//
// Ports:
//   clk              FIFO conduit clock
//   reset_n          asynchronous active-low reset
//   enable           run request
//   out_readdata     HPS-to-FPGA FIFO data (valid the cycle after out_read)
//   out_read         HPS-to-FPGA FIFO read strobe
//   out_csr_address  HPS-to-FPGA FIFO CSR address (fill_level, always 0)
//   out_csr_read     HPS-to-FPGA FIFO CSR read strobe
//   out_csr_readdata HPS-to-FPGA FIFO CSR read data (fill level)
//   in_writedata     FPGA-to-HPS FIFO write data
//   in_write         FPGA-to-HPS FIFO write strobe
//   in_csr_address   FPGA-to-HPS FIFO CSR address (fill_level, always 0)
//   in_csr_read      FPGA-to-HPS FIFO CSR read strobe
//   in_csr_readdata  FPGA-to-HPS FIFO CSR read data (fill level)
//   word_count       words forwarded since reset (wraps at 2^32)
//   busy             high in every state except IDLE
// -----------------------------------------------------------------------------
module fifo_loopback_engine #(
    parameter int unsigned FIFO_DEPTH = 256,
    parameter logic [31:0] ADD_VALUE  = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] out_readdata,
    output logic        out_read,
    output logic [2:0]  out_csr_address,
    output logic        out_csr_read,
    input  logic [31:0] out_csr_readdata,
    output logic [31:0] in_writedata,
    output logic        in_write,
    output logic [2:0]  in_csr_address,
    output logic        in_csr_read,
    input  logic [31:0] in_csr_readdata,
    output logic [31:0] word_count,
    output logic        busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_POLL_OUT  = 3'd1;
    localparam logic [2:0] S_WAIT_OUT  = 3'd2;
    localparam logic [2:0] S_POLL_IN   = 3'd3;
    localparam logic [2:0] S_WAIT_IN   = 3'd4;
    localparam logic [2:0] S_READ      = 3'd5;
    localparam logic [2:0] S_WAIT_DATA = 3'd6;
    localparam logic [2:0] S_WRITE     = 3'd7;

    localparam logic [31:0] DEPTH_W = 32'(FIFO_DEPTH);

    logic [2:0]  state_q,  state_d;
    logic [31:0] avail_q,  avail_d;
    logic [31:0] space_q,  space_d;
    logic [31:0] burst_q,  burst_d;
    logic [31:0] data_q,   data_d;
    logic        loaded_q, loaded_d;
    logic [31:0] count_q,  count_d;

    logic [31:0] space_calc;
    logic [31:0] burst_calc;
    logic [31:0] burst_dec;

    // Free space downstream, saturating at 0 if the reported level ever
    // meets or exceeds the configured depth.
    always_comb begin
        if (in_csr_readdata >= DEPTH_W) begin
            space_calc = '0;
        end else begin
            space_calc = DEPTH_W - in_csr_readdata;
        end
        burst_calc = (avail_q < space_calc) ? avail_q : space_calc;
        burst_dec  = burst_q - 32'd1;
    end

    always_comb begin
        state_d  = state_q;
        avail_d  = avail_q;
        space_d  = space_q;
        burst_d  = burst_q;
        data_d   = data_q;
        loaded_d = loaded_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_POLL_OUT;
                end
            end
            S_POLL_OUT: begin
                state_d = S_WAIT_OUT;
            end
            S_WAIT_OUT: begin
                avail_d = out_csr_readdata;
                if (!enable || (out_csr_readdata == 32'd0)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_POLL_IN;
                end
            end
            S_POLL_IN: begin
                state_d = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                space_d = space_calc;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (space_calc == 32'd0) begin
                    // avail_q is kept; only the downstream level is re-polled
                    state_d = S_POLL_IN;
                end else begin
                    burst_d = burst_calc;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Once a word is read it is always written, so enable is
                // ignored here and in WAIT_DATA.
                state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                data_d   = out_readdata;
                loaded_d = 1'b1;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                count_d = count_q + 32'd1;
                burst_d = burst_dec;
                if ((burst_dec != 32'd0) && enable) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            avail_q  <= '0;
            space_q  <= '0;
            burst_q  <= '0;
            data_q   <= '0;
            loaded_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            avail_q  <= avail_d;
            space_q  <= space_d;
            burst_q  <= burst_d;
            data_q   <= data_d;
            loaded_q <= loaded_d;
            count_q  <= count_d;
        end
    end

    // Strobes are decoded straight from the state register so that an
    // asynchronous reset drops them in the same cycle. The write data is
    // formed from the captured word and forced to 0 until a word has been
    // captured, so it reads 0 after reset and holds between writes.
    assign out_csr_read    = (state_q == S_POLL_OUT);
    assign in_csr_read     = (state_q == S_POLL_IN);
    assign out_read        = (state_q == S_READ);
    assign in_write        = (state_q == S_WRITE);
    assign busy            = (state_q != S_IDLE);
    assign out_csr_address = '0;
    assign in_csr_address  = '0;
    assign in_writedata    = loaded_q ? (data_q + ADD_VALUE) : '0;
    assign word_count      = count_q;

endmodule

// File: tb/tb_fifo_loopback_engine.sv
module tb_fifo_loopback_engine;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] ADDV  = 32'd1;
    localparam int unsigned MEMN  = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] out_readdata = '0;
    logic        out_read;
    logic [2:0]  out_csr_address;
    logic        out_csr_read;
    logic [31:0] out_csr_readdata = '0;
    logic [31:0] in_writedata;
    logic        in_write;
    logic [2:0]  in_csr_address;
    logic        in_csr_read;
    logic [31:0] in_csr_readdata = '0;
    logic [31:0] word_count;
    logic        busy;

    always #5 clk = ~clk;

    fifo_loopback_engine #(
        .FIFO_DEPTH(DEPTH),
        .ADD_VALUE (ADDV)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .out_readdata    (out_readdata),
        .out_read        (out_read),
        .out_csr_address (out_csr_address),
        .out_csr_read    (out_csr_read),
        .out_csr_readdata(out_csr_readdata),
        .in_writedata    (in_writedata),
        .in_write        (in_write),
        .in_csr_address  (in_csr_address),
        .in_csr_read     (in_csr_read),
        .in_csr_readdata (in_csr_readdata),
        .word_count      (word_count),
        .busy            (busy)
    );

    // ---------------- Avalon FIFO models (read latency 1) ----------------
    logic [31:0] out_mem [MEMN];
    logic [31:0] exp_mem [MEMN];
    int unsigned out_wp = 0;     // written by the stimulus process only
    int unsigned out_rp = 0;     // written by the FIFO model only
    int          in_base = 0;    // stimulus-side part of the in-FIFO level
    int unsigned in_wr_cnt = 0;  // words the engine has written

    always @(posedge clk) begin
        if (out_csr_read) out_csr_readdata <= 32'(out_wp - out_rp);
        if (out_read) begin
            if (out_rp != out_wp) begin
                out_readdata <= out_mem[out_rp % MEMN];
                out_rp <= out_rp + 1;
            end else begin
                out_readdata <= 32'hDEADBEEF;
            end
        end
        if (in_csr_read) in_csr_readdata <= 32'(in_base + int'(in_wr_cnt));
        if (in_write) in_wr_cnt <= in_wr_cnt + 1;
    end

    // ---------------- checking state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int unsigned wc_model = 0;
    int unsigned mon_rd = 0;
    logic        infl_v = 1'b0;
    logic [31:0] infl_exp = '0;
    logic [31:0] last_wd = '0;
    int rd_cyc = 0;
    int cnt_or = 0, cnt_iw = 0, cnt_oc = 0, cnt_ic = 0, busy_lo = 0;
    logic [31:0] wr_log_d[$];
    int          wr_log_c[$];

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    typedef struct {
        int avail;
        int in_level;
        int exp_words;
    } burst_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int in_level();
        return in_base + int'(in_wr_cnt);
    endfunction

    task automatic set_in_level(input int lvl);
        in_base = lvl - int'(in_wr_cnt);
    endtask

    task automatic push_word(input logic [31:0] d);
        out_mem[out_wp % MEMN] = d;
        exp_mem[out_wp % MEMN] = d + ADDV;
        out_wp++;
    endtask

    // One clock: wait for the falling edge, then check the bus against the
    // stream model (every word read comes back +ADDV exactly 2 cycles later).
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!reset_n) begin
            chk("reset_strobes", {out_read, out_csr_read, in_csr_read, in_write, busy,
                                  out_csr_address, in_csr_address}, '0);
            chk("reset_word_count", word_count, '0);
            chk("reset_writedata", in_writedata, '0);
            wc_model = 0;
            infl_v = 1'b0;
            last_wd = '0;
        end else begin
            chk("word_count", word_count, wc_model);
            chk("csr_address", {out_csr_address, in_csr_address}, '0);
            if (out_read || out_csr_read || in_csr_read || in_write) chk("busy_with_strobe", busy, 1);
            if (!busy) busy_lo++;
            if (out_csr_read) cnt_oc++;
            if (in_csr_read) cnt_ic++;
            if (out_read) begin
                cnt_or++;
                chk("read_while_outstanding", infl_v, 0);
                chk("read_from_nonempty", (mon_rd != out_wp), 1);
                if (mon_rd != out_wp) begin
                    infl_exp = exp_mem[mon_rd % MEMN];
                    mon_rd++;
                end
                infl_v = 1'b1;
                rd_cyc = cyc;
            end
            if (in_write) begin
                cnt_iw++;
                chk("write_has_read", infl_v, 1);
                chk("read_to_write_latency", 64'(cyc - rd_cyc), 64'd2);
                chk("write_data", in_writedata, infl_exp);
                chk("no_overflow", (in_level() < int'(DEPTH)), 1);
                wr_log_d.push_back(in_writedata);
                wr_log_c.push_back(cyc);
                last_wd = in_writedata;
                wc_model++;
                infl_v = 1'b0;
            end else begin
                chk("writedata_hold", in_writedata, last_wd);
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("reach_idle", busy, 0);
    endtask

    task automatic wait_read(input string nm);
        int n = 0;
        while (!out_read && n < 40) begin
            tick();
            n++;
        end
        chk(nm, out_read, 1);
    endtask

    // Stop, empty the source FIFO and set the downstream level.
    task automatic setup_case(input int lvl);
        enable = 1'b0;
        wait_idle();
        out_wp = out_rp;
        set_in_level(lvl);
    endtask

    initial begin
        vec_t   tbl[3];
        burst_t btbl[7];
        int b_or, b_iw, b_oc, b_ic, b_lo, base, fp, fr, fi, n;

        tbl[0] = '{32'h0000_0010, 32'h0000_0011};
        tbl[1] = '{32'h0000_0020, 32'h0000_0021};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000};

        btbl[0] = '{5, 254, 2};
        btbl[1] = '{2, 10, 2};
        btbl[2] = '{4, 253, 3};
        btbl[3] = '{1, 255, 1};
        btbl[4] = '{6, 300, 0};
        btbl[5] = '{3, 256, 0};
        btbl[6] = '{7, 0, 7};

        // ---- reset held with enable high ----
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (4) tick();
        reset_n = 1'b1;
        tick();
        chk("first_poll_after_release", out_csr_read, 1);
        tick();
        chk("poll_is_single_pulse", out_csr_read, 0);

        // ---- empty source: P,W,I repeating, nothing forwarded ----
        b_oc = cnt_oc; b_lo = busy_lo; b_or = cnt_or; b_ic = cnt_ic;
        repeat (30) tick();
        chk("empty_out_polls", 64'(cnt_oc - b_oc), 64'd10);
        chk("empty_idle_cycles", 64'(busy_lo - b_lo), 64'd10);
        chk("empty_no_reads", 64'(cnt_or - b_or), 64'd0);
        chk("empty_no_in_polls", 64'(cnt_ic - b_ic), 64'd0);

        // ---- basic forward, table-driven ----
        setup_case(0);
        foreach (tbl[i]) push_word(tbl[i].din);
        base = wr_log_d.size();
        enable = 1'b1;
        fp = -1; fr = -1; fi = -1; n = 0;
        while (wr_log_d.size() < base + 3 && n < 60) begin
            tick();
            if (out_csr_read && fp < 0) fp = cyc;
            if (in_csr_read && fi < 0) fi = cyc;
            if (out_read && fr < 0) fr = cyc;
            n++;
        end
        chk("basic_write_count", 64'(wr_log_d.size() - base), 64'd3);
        chk("poll_in_offset", 64'(fi - fp), 64'd2);
        chk("poll_overhead", 64'(fr - fp), 64'd4);
        for (int i = 0; i < 3; i++) begin
            if (base + i < wr_log_d.size()) begin
                chk("basic_data", wr_log_d[base + i], tbl[i].dout);
                if (i > 0) chk("basic_spacing", 64'(wr_log_c[base + i] - wr_log_c[base + i - 1]), 64'd3);
            end
        end
        tick();
        chk("basic_word_count", word_count, 64'd3);

        // ---- downstream full, then two slots open ----
        setup_case(256);
        for (int i = 0; i < 5; i++) push_word($urandom);
        enable = 1'b1;
        n = 0;
        while (!in_csr_read && n < 20) begin tick(); n++; end
        chk("full_first_in_poll", in_csr_read, 1);
        b_ic = cnt_ic; b_or = cnt_or;
        repeat (20) tick();
        chk("full_in_poll_rate", 64'(cnt_ic - b_ic), 64'd10);
        chk("full_no_reads", 64'(cnt_or - b_or), 64'd0);
        set_in_level(254);
        b_or = cnt_or; b_iw = cnt_iw; b_oc = cnt_oc;
        repeat (60) tick();
        chk("partial_reads", 64'(cnt_or - b_or), 64'd2);
        chk("partial_writes", 64'(cnt_iw - b_iw), 64'd2);
        chk("partial_repoll", 64'(cnt_oc - b_oc), 64'd1);

        // ---- burst size = min(avail, space), table-driven ----
        foreach (btbl[k]) begin
            setup_case(btbl[k].in_level);
            for (int i = 0; i < btbl[k].avail; i++) push_word($urandom);
            b_or = cnt_or; b_iw = cnt_iw; b_ic = cnt_ic;
            enable = 1'b1;
            repeat (60) tick();
            chk("burst_reads", 64'(cnt_or - b_or), 64'(btbl[k].exp_words));
            chk("burst_writes", 64'(cnt_iw - b_iw), 64'(btbl[k].exp_words));
            if (btbl[k].exp_words == 0) chk("burst_full_polling", (cnt_ic - b_ic) > 20, 1);
        end

        // ---- enable dropped in the READ cycle ----
        setup_case(0);
        for (int i = 0; i < 4; i++) push_word($urandom);
        b_or = cnt_or; b_iw = cnt_iw;
        enable = 1'b1;
        wait_read("enable_drop_read_seen");
        enable = 1'b0;
        tick();
        tick();
        chk("enable_drop_write", in_write, 1);
        b_lo = busy_lo; b_oc = cnt_oc;
        repeat (10) tick();
        chk("enable_drop_idle", 64'(busy_lo - b_lo), 64'd10);
        chk("enable_drop_no_poll", 64'(cnt_oc - b_oc), 64'd0);
        chk("enable_drop_reads", 64'(cnt_or - b_or), 64'd1);
        chk("enable_drop_writes", 64'(cnt_iw - b_iw), 64'd1);

        // ---- async reset in WAIT_DATA ----
        enable = 1'b1;
        wait_read("async_reset_read_seen");
        tick();
        reset_n = 1'b0;
        #1;
        chk("async_reset_strobes", {out_read, out_csr_read, in_csr_read, in_write, busy}, '0);
        chk("async_reset_word_count", word_count, '0);
        chk("async_reset_writedata", in_writedata, '0);
        repeat (3) tick();
        enable = 1'b0;
        reset_n = 1'b1;
        b_iw = cnt_iw;
        repeat (6) tick();
        chk("async_reset_no_write", 64'(cnt_iw - b_iw), 64'd0);
        chk("async_reset_count_zero", word_count, '0);

        // ---- randomized traffic against the stream model ----
        setup_case(200);
        enable = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                for (int j = 0; j < int'($urandom_range(1, 4)); j++) push_word($urandom);
            end else if (r < 30) begin
                int lvl;
                lvl = in_level();
                if (lvl > 0) set_in_level(lvl - int'($urandom_range(0, lvl)));
            end else if (r < 33) begin
                enable = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        enable = 1'b1;
        n = 0;
        while ((mon_rd != out_wp || infl_v) && n < 8000) begin
            set_in_level(0);
            tick();
            n++;
        end
        chk("random_all_forwarded", 64'(out_wp - mon_rd), 64'd0);
        enable = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
